m3_commutation_sequencer: RTL and testbench
===========================================

Name: m3_commutation_sequencer

Overview:
- Six-step commutation controller for the three-phase bridge. It drives aHP/aLN/bHP/bLN/cHP/cLN directly.
- Sequences the bridge legs with enforced dead time, a soft-start/stop period ramp, user frequency trim (INC/DEC), controlled direction reversal and immediate force-stop.
- Sits between the button/sync logic and the bridge pins inside the motor top level.

Parameters:
- DEAD_CYC, 50: all-off cycles between drive steps (1 us at 50 MHz).
- PER_W, 24: width of period counters/registers.
- PER_MAX, 500000: slowest step period in cycles; used as start/stop/reversal period.
- PER_MIN, 5000: fastest allowed step period.
- PER_INIT, 50000: user target period after reset.
- FREQ_STEP, 1000: target change per INC/DEC event.
- RAMP_STEP, 2000: maximum change of current period per commutation.

Ports:
- clk50mhz, input, 1: system clock, 50 MHz.
- nReset, input, 1: asynchronous active-low reset.
- m3start, input, 1: level; run request (synchronized upstream).
- m3forceStop, input, 1: level; immediate stop, priority over everything.
- m3invRotate, input, 1: level; 0 = forward, 1 = reverse.
- m3freqINC, input, 1: rising edge shortens target period.
- m3freqDEC, input, 1: rising edge lengthens target period.
- aHP / aLN / bHP / bLN / cHP / cLN, output, 1 each: high/low-side switch enables, active-high, registered.
- step_idx, output, 3: current commutation step, 0..5.
- running, output, 1: 1 when state is not IDLE.
- dir, output, 1: direction currently applied.
- cur_period, output, PER_W: period in use.

Behaviour:
- Reset (async, nReset=0):
  - All six drive outputs = 0.
  - step_idx = 0, running = 0, dir = 0.
  - cur_period = PER_MAX, target = PER_INIT.
  - State = IDLE; edge-detect registers cleared.
- States:
  - IDLE → DEAD when m3start=1 & m3forceStop=0. dir latches m3invRotate and step_idx = 0 on this transition.
  - DEAD lasts exactly DEAD_CYC cycles with all outputs 0, then → DRIVE.
  - DRIVE lasts exactly cur_period cycles, then the commutation boundary → DEAD.
  - If m3start=0 at the boundary → IDLE instead of DEAD. The current DRIVE always completes. Outputs go to 0 on the boundary and cur_period resets to PER_MAX.
- Step decode (outputs registered from state and step_idx):
  - 0: aHP, bLN
  - 1: aHP, cLN
  - 2: bHP, cLN
  - 3: bHP, aLN
  - 4: cHP, aLN
  - 5: cHP, bLN
  - All other outputs in each step = 0.
- Invariant: xHP & xLN is never 1 for any leg, in any cycle including reset and force-stop.
- Commutation boundary actions:
  - step_idx advances +1 mod 6 if dir=0, −1 mod 6 if dir=1 (0→5).
  - cur_period moves toward the effective target by at most RAMP_STEP. It snaps to the target when within RAMP_STEP.
  - Step-to-step interval = cur_period + DEAD_CYC.
- Frequency trim:
  - Rising edge of m3freqINC: target −= FREQ_STEP, clamped to PER_MIN.
  - Rising edge of m3freqDEC: target += FREQ_STEP, clamped to PER_MAX.
  - Both edges in the same cycle: target unchanged.
  - Accepted in any state; trim in IDLE persists.
- Reversal:
  - While running, m3invRotate ≠ dir → effective target = PER_MAX, so the motor ramps down.
  - At the boundary where cur_period == PER_MAX, dir flips and the effective target returns to the user target.
  - If m3invRotate returns to match dir before the flip, the reversal is cancelled.
- Force-stop:
  - m3forceStop=1 in any state → next clock all outputs 0, state IDLE, running 0, cur_period PER_MAX, step_idx 0. Target is kept.
  - Stays IDLE while m3forceStop=1.
- Counters: a single down-counter is reused by DEAD and DRIVE; it is reloaded on every state entry. No wrap is possible.

Test Plan (DEAD_CYC=4, PER_MAX=40, PER_MIN=10, PER_INIT=20, FREQ_STEP=5, RAMP_STEP=10):
- Reset, then m3start=1 → 4 cycles all-off, then:
  - aHP=bLN=1 for 40 cycles, 4 off;
  - aHP=cLN=1 for 30 cycles;
  - bHP=cLN for 20 cycles;
  - then 20-cycle steps through 3, 4, 5, 0.
- Three INC pulses at steady state → target 15, 10, 10 (clamped). Periods go 15 then 10. Then 8 DEC pulses → target 40.
- m3invRotate=1 at period 20 → periods 30, 40; dir flips; step_idx decrements (e.g. 2→1→0→5); periods ramp 30, 20.
- m3forceStop pulse mid-DRIVE → all outputs 0 next cycle and running=0. Release with m3start=1 → restart at step 0, period 40.
- m3start=0 mid-DRIVE → step completes its full count, then all outputs 0, running=0, no DEAD entry. Also: INC and DEC rising in the same cycle → target unchanged.
- nReset low mid-DRIVE → outputs 0 without a clock edge. Assertion checked every cycle in all tests: no leg has xHP & xLN; no cycle has exactly one of the six outputs high while running in DRIVE.

Source files
------------

// File: rtl/m3_commutation_sequencer.sv
// m3_commutation_sequencer: six-step bridge commutation with dead time, period ramp, trim, reversal and force-stop
// Ports: clk50mhz/nReset clock and async active-low reset; m3start run request level;
//   m3forceStop immediate stop; m3invRotate requested direction; m3freqINC/m3freqDEC trim edges;
//   aHP..cLN registered switch enables; step_idx/running/dir/cur_period sequencer status.
module m3_commutation_sequencer #(
   parameter int DEAD_CYC  = 50,
   parameter int PER_W     = 24,
   parameter int PER_MAX   = 500000,
   parameter int PER_MIN   = 5000,
   parameter int PER_INIT  = 50000,
   parameter int FREQ_STEP = 1000,
   parameter int RAMP_STEP = 2000
) (
   input  logic             clk50mhz,
   input  logic             nReset,
   input  logic             m3start,
   input  logic             m3forceStop,
   input  logic             m3invRotate,
   input  logic             m3freqINC,
   input  logic             m3freqDEC,
   output logic             aHP,
   output logic             aLN,
   output logic             bHP,
   output logic             bLN,
   output logic             cHP,
   output logic             cLN,
   output logic [2:0]       step_idx,
   output logic             running,
   output logic             dir,
   output logic [PER_W-1:0] cur_period
);
   localparam logic [PER_W-1:0] P_MAX  = PER_W'(PER_MAX);
   localparam logic [PER_W-1:0] P_MIN  = PER_W'(PER_MIN);
   localparam logic [PER_W-1:0] P_INIT = PER_W'(PER_INIT);
   localparam logic [PER_W-1:0] F_STEP = PER_W'(FREQ_STEP);
   localparam logic [PER_W-1:0] R_STEP = PER_W'(RAMP_STEP);
   localparam logic [PER_W-1:0] D_LOAD = PER_W'(DEAD_CYC - 1);
   localparam logic [PER_W-1:0] ONE    = PER_W'(1);

   typedef enum logic [1:0] {IDLE, DEAD, DRIVE} state_t;

   state_t           state, nextState;
   logic [PER_W-1:0] cnt, nextCnt, target, nextTarget, nextPeriod, effTarget, ramped;
   logic [2:0]       nextStep, stepFwd, stepRev;
   logic             nextDir, incQ, decQ, incRise, decRise, reversing, flip;
   logic [5:0]       legs, nextLegs;

   assign {aHP, aLN, bHP, bLN, cHP, cLN} = legs;
   assign running = state != IDLE;

   always_comb begin
      incRise = m3freqINC & ~incQ;
      decRise = m3freqDEC & ~decQ;
      nextTarget = (incRise & ~decRise) ? ((target < P_MIN + F_STEP) ? P_MIN : target - F_STEP)
                 : (decRise & ~incRise) ? ((target > P_MAX - F_STEP) ? P_MAX : target + F_STEP)
                 : target;
      // a pending reversal pulls the ramp to PER_MAX; once there the direction flips
      reversing = m3invRotate != dir;
      flip = reversing && cur_period == P_MAX;
      effTarget = (reversing && !flip) ? P_MAX : target;
      ramped = (effTarget > cur_period)
             ? ((effTarget - cur_period > R_STEP) ? cur_period + R_STEP : effTarget)
             : ((cur_period - effTarget > R_STEP) ? cur_period - R_STEP : effTarget);
      stepFwd = (step_idx == 3'd5) ? 3'd0 : step_idx + 3'd1;
      stepRev = (step_idx == 3'd0) ? 3'd5 : step_idx - 3'd1;
      nextState = state;
      nextCnt = (state == IDLE) ? cnt : cnt - ONE;
      nextStep = step_idx;
      nextDir = dir;
      nextPeriod = cur_period;
      case (state)
         IDLE: if (m3start) begin
            nextState = DEAD;
            nextCnt = D_LOAD;
            nextStep = 3'd0;
            nextDir = m3invRotate;
         end
         DEAD: if (cnt == '0) begin
            nextState = DRIVE;
            nextCnt = cur_period - ONE;
         end
         DRIVE: if (cnt == '0) begin
            nextDir = dir ^ flip;
            nextStep = (dir ^ flip) ? stepRev : stepFwd;
            nextState = m3start ? DEAD : IDLE;
            nextCnt = D_LOAD;
            nextPeriod = m3start ? ramped : P_MAX;
         end
         default: nextState = IDLE;
      endcase
      if (m3forceStop) begin
         nextState = IDLE;
         nextPeriod = P_MAX;
         nextStep = 3'd0;
      end
      // outputs are registered from the upcoming state so they are high exactly during DRIVE
      case (nextStep)
         3'd0: nextLegs = 6'b100100;
         3'd1: nextLegs = 6'b100001;
         3'd2: nextLegs = 6'b001001;
         3'd3: nextLegs = 6'b011000;
         3'd4: nextLegs = 6'b010010;
         3'd5: nextLegs = 6'b000110;
         default: nextLegs = 6'b000000;
      endcase
      if (nextState != DRIVE) nextLegs = 6'b000000;
   end

   always_ff @(posedge clk50mhz or negedge nReset) begin
      if (!nReset) begin
         state <= IDLE;
         cnt <= '0;
         target <= P_INIT;
         cur_period <= P_MAX;
         step_idx <= 3'd0;
         dir <= 1'b0;
         incQ <= 1'b0;
         decQ <= 1'b0;
         legs <= 6'b000000;
      end else begin
         state <= nextState;
         cnt <= nextCnt;
         target <= nextTarget;
         cur_period <= nextPeriod;
         step_idx <= nextStep;
         dir <= nextDir;
         incQ <= m3freqINC;
         decQ <= m3freqDEC;
         legs <= nextLegs;
      end
   end
endmodule

// File: tb/tb_m3_commutation_sequencer.sv
// tb_m3_commutation_sequencer: self-checking bench with a behavioural reference model
module tb_m3_commutation_sequencer;
   localparam int DEAD = 4, PMAX = 40, PMIN = 10, PINIT = 20, FS = 5, R = 10;

   logic clk = 1'b0, nReset, m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC;
   logic aHP, aLN, bHP, bLN, cHP, cLN, running, dir;
   logic [2:0] step_idx;
   logic [23:0] cur_period;
   logic [5:0] drv;
   int passCnt = 0, totCnt = 0;
   bit chkOn = 0;

   assign drv = {aHP, aLN, bHP, bLN, cHP, cLN};

   m3_commutation_sequencer #(
      .DEAD_CYC(DEAD), .PER_W(24), .PER_MAX(PMAX), .PER_MIN(PMIN),
      .PER_INIT(PINIT), .FREQ_STEP(FS), .RAMP_STEP(R)
   ) dut (
      .clk50mhz(clk), .nReset(nReset), .m3start(m3start), .m3forceStop(m3forceStop),
      .m3invRotate(m3invRotate), .m3freqINC(m3freqINC), .m3freqDEC(m3freqDEC),
      .aHP(aHP), .aLN(aLN), .bHP(bHP), .bLN(bLN), .cHP(cHP), .cLN(cLN),
      .step_idx(step_idx), .running(running), .dir(dir), .cur_period(cur_period)
   );

   always #5 clk = ~clk;

   // reference model: left counts cycles remaining in the current dead/drive phase
   typedef struct {
      bit run, drv, dir;
      int left, step, per, tgt;
      bit pInc, pDec;
   } mdl_t;
   mdl_t m;
   int hiLeg [6] = '{0, 0, 1, 1, 2, 2};
   int loLeg [6] = '{1, 2, 2, 0, 0, 1};

   function automatic mdl_t mdlNext(mdl_t c, bit st, bit fs, bit inv, bit fi, bit fd);
      mdl_t n = c;
      bit rev;
      int eff;
      n.pInc = fi;
      n.pDec = fd;
      if (fs) begin
         n.run = 0; n.drv = 0; n.per = PMAX; n.step = 0;
      end else if (!c.run) begin
         if (st) begin n.run = 1; n.drv = 0; n.left = DEAD; n.step = 0; n.dir = inv; end
      end else if (c.left > 1) n.left = c.left - 1;
      else if (!c.drv) begin
         n.drv = 1; n.left = c.per;
      end else begin
         rev = inv != c.dir;
         if (rev && c.per == PMAX) begin n.dir = !c.dir; rev = 0; end
         n.step = (c.step + (n.dir ? 5 : 1)) % 6;
         eff = rev ? PMAX : c.tgt;
         n.drv = 0;
         n.left = DEAD;
         if (st) n.per = (c.per < eff) ? ((c.per + R < eff) ? c.per + R : eff)
                                       : ((c.per - R > eff) ? c.per - R : eff);
         else begin n.run = 0; n.per = PMAX; end
      end
      if (fi && !c.pInc && !(fd && !c.pDec)) n.tgt = (c.tgt - FS < PMIN) ? PMIN : c.tgt - FS;
      else if (fd && !c.pDec && !(fi && !c.pInc)) n.tgt = (c.tgt + FS > PMAX) ? PMAX : c.tgt + FS;
      return n;
   endfunction

   function automatic logic [5:0] mdlDrive(mdl_t c);
      logic [5:0] v = '0;
      if (c.drv) begin
         v[5 - 2 * hiLeg[c.step]] = 1'b1;
         v[4 - 2 * loLeg[c.step]] = 1'b1;
      end
      return v;
   endfunction

   always @(posedge clk or negedge nReset)
      if (!nReset) m <= '{0, 0, 0, 0, 0, PMAX, PINIT, 0, 0};
      else m <= mdlNext(m, m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC);

   task automatic chk(input string nm, input longint got, input longint exp);
      totCnt++;
      if (got == exp) passCnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
   endtask

   always @(negedge clk) if (chkOn) begin
      chk("running", running, m.run);
      chk("step_idx", step_idx, m.step);
      chk("dir", dir, m.dir);
      chk("cur_period", cur_period, m.per);
      chk("drive", drv, mdlDrive(m));
      chk("leg_a_shoot", aHP & aLN, 0);
      chk("leg_b_shoot", bHP & bLN, 0);
      chk("leg_c_shoot", cHP & cLN, 0);
      if (running) chk("single_on", $countones(drv) == 1, 0);
   end

   task automatic waitDrive(output int off, output logic [5:0] pat, output int len, output int st);
      off = 0; len = 0; pat = '0; st = 0;
      while (drv == 0 && off < 2000) begin off++; @(negedge clk); end
      if (drv == 0) begin
         totCnt++;
         $display("FAIL drive_timeout: got no drive after %0d cycles expected a drive step", off);
         return;
      end
      pat = drv;
      st = step_idx;
      while (drv == pat && len < 2000) begin len++; @(negedge clk); end
   endtask

   task automatic pulse(input bit dec);
      if (dec) m3freqDEC = 1; else m3freqINC = 1;
      @(negedge clk);
      m3freqINC = 0; m3freqDEC = 0;
      @(negedge clk);
   endtask

   task automatic waitOn();
      int w = 0;
      while (drv == 0 && w < 2000) begin w++; @(negedge clk); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int off, len, st, lens[5], sts[5];
      logic [5:0] pat;
      logic [5:0] seqPat [4] = '{6'b011000, 6'b010010, 6'b000110, 6'b100100};
      nReset = 0; m3start = 0; m3forceStop = 0; m3invRotate = 0; m3freqINC = 0; m3freqDEC = 0;
      repeat (3) @(negedge clk);
      nReset = 1;
      chkOn = 1;
      chk("rst_drive", drv, 0);
      chk("rst_running", running, 0);
      chk("rst_period", cur_period, 40);
      chk("rst_step", step_idx, 0);
      chk("rst_dir", dir, 0);
      // soft start 40 -> 30 -> 20
      m3start = 1;
      @(negedge clk);
      waitDrive(off, pat, len, st);
      chk("start_dead", off, 4); chk("s0_pat", pat, 6'b100100); chk("s0_len", len, 40);
      waitDrive(off, pat, len, st);
      chk("s1_dead", off, 4); chk("s1_pat", pat, 6'b100001); chk("s1_len", len, 30);
      waitDrive(off, pat, len, st);
      chk("s2_pat", pat, 6'b001001); chk("s2_len", len, 20);
      for (int i = 0; i < 4; i++) begin
         waitDrive(off, pat, len, st);
         chk("steady_pat", pat, seqPat[i]); chk("steady_len", len, 20);
      end
      // trim: 20 -> 15 -> 10 (clamped)
      pulse(0);
      waitDrive(off, pat, len, st); chk("inc1_keep", len, 20);
      waitDrive(off, pat, len, st); chk("inc1_len", len, 15);
      pulse(0); pulse(0);
      waitDrive(off, pat, len, st); chk("inc2_keep", len, 15);
      waitDrive(off, pat, len, st); chk("inc2_len", len, 10);
      chk("inc_clamp_period", cur_period, 10);
      for (int i = 0; i < 8; i++) pulse(1);
      for (int i = 0; i < 10; i++) begin
         waitDrive(off, pat, len, st);
         if (len == 40) break;
      end
      chk("dec_reach_max", len, 40);
      for (int i = 0; i < 4; i++) pulse(0);
      for (int i = 0; i < 10; i++) begin
         waitDrive(off, pat, len, st);
         if (len == 20) break;
      end
      chk("inc_back_20", len, 20);
      // reversal: ramp to PER_MAX, flip, ramp back
      m3invRotate = 1;
      for (int i = 0; i < 5; i++) begin
         waitDrive(off, pat, len, st);
         lens[i] = len; sts[i] = st;
      end
      chk("rev_len0", lens[0], 20); chk("rev_len1", lens[1], 30); chk("rev_len2", lens[2], 40);
      chk("rev_len3", lens[3], 30); chk("rev_len4", lens[4], 20);
      chk("rev_fwd_step", sts[2], (sts[1] + 1) % 6);
      chk("rev_back_step1", sts[3], (sts[2] + 5) % 6);
      chk("rev_back_step2", sts[4], (sts[3] + 5) % 6);
      chk("rev_dir", dir, 1);
      // force-stop mid drive
      waitOn();
      repeat (5) @(negedge clk);
      m3forceStop = 1;
      @(negedge clk);
      chk("fs_drive", drv, 0); chk("fs_running", running, 0);
      chk("fs_period", cur_period, 40); chk("fs_step", step_idx, 0);
      repeat (3) @(negedge clk);
      chk("fs_hold_running", running, 0);
      m3forceStop = 0;
      @(negedge clk);
      waitDrive(off, pat, len, st);
      chk("fs_restart_dead", off, 4); chk("fs_restart_pat", pat, 6'b100100);
      chk("fs_restart_len", len, 40); chk("fs_restart_dir", dir, 1);
      // normal stop: the current drive completes, then idle
      waitOn();
      pat = drv; st = step_idx; len = 0;
      while (drv == pat && len < 2000) begin
         len++;
         if (len == 5) m3start = 0;
         @(negedge clk);
      end
      chk("stop_len", len, 30); chk("stop_step", st, 5);
      chk("stop_running", running, 0); chk("stop_period", cur_period, 40);
      repeat (10) @(negedge clk);
      chk("stop_idle_running", running, 0); chk("stop_idle_drive", drv, 0);
      // simultaneous INC and DEC edges leave the target at 20
      m3freqINC = 1; m3freqDEC = 1;
      @(negedge clk);
      m3freqINC = 0; m3freqDEC = 0;
      @(negedge clk);
      m3start = 1;
      @(negedge clk);
      waitDrive(off, pat, len, st); chk("both_len0", len, 40);
      waitDrive(off, pat, len, st); chk("both_len1", len, 30);
      waitDrive(off, pat, len, st); chk("both_len2", len, 20);
      waitDrive(off, pat, len, st); chk("both_len3", len, 20);
      // asynchronous reset mid drive
      waitOn();
      repeat (3) @(negedge clk);
      #2 nReset = 0;
      #1;
      chk("arst_drive", drv, 0); chk("arst_running", running, 0); chk("arst_period", cur_period, 40);
      @(negedge clk);
      nReset = 1;
      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", passCnt, totCnt);
      $finish;
   end
endmodule
